slave_packet_server: RTL and testbench

Parametrised packet read slave, successor to the single-bank header+RAM read slave.
- Write side captures a stream of DATA_W words from a generator into a ping-pong buffer of two DEPTH-word banks.
- Read side serves a complete packet at address-indexed reads: HDR_WORDS words of big-endian sequence number, then DEPTH payload words.
- Bank swap is handshaked, so the reader never sees a partially written packet.
- Sits between the on-chip data generator and the host read interface.

---
 rtl/slave_packet_pkg.sv | 27 ++
 rtl/pingpong_ram.sv | 39 +++
 rtl/slave_packet_server.sv | 143 ++++++++++++++
 tb/tb_slave_packet_server.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/slave_packet_pkg.sv
// Shared types and helpers for the ping-pong packet read slave.
// Header words are big-endian slices of the packet sequence counter.
package slave_packet_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_HDR_WORDS = 2;
  localparam int MAX_SEQ_W     = 256;

  typedef enum logic {W_FILL, W_FULL} w_state_t;
  typedef enum logic {R_EMPTY, R_HOLD} r_state_t;

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Word 0 is the most significant data_w bits; the caller truncates to data_w.
  function automatic logic [MAX_SEQ_W-1:0] hdr_word(input logic [MAX_SEQ_W-1:0] seq,
                                                    input int idx,
                                                    input int data_w,
                                                    input int hdr_words);
    return seq >> (data_w * (hdr_words - 1 - idx));
  endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Simple dual-port memory holding both packet banks; address = {bank, index}.
// Synchronous write, synchronous read with one cycle of latency.
module pingpong_ram
  import slave_packet_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter bit DEBUG_MODE = 1'b1,
  parameter int AW         = idx_width(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2*DEPTH];

  generate
    if (DEBUG_MODE) begin : g_behav
      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
      end
    end else begin : g_vendor
      // Registered-address template that block-RAM inference maps directly.
      logic [AW-1:0] rd_addr_q;
      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_addr_q <= rd_addr;
      end
      assign rd_data = mem[rd_addr_q];
    end
  endgenerate

endmodule

// File: rtl/slave_packet_server.sv
// Packet read slave: generator fills one bank while the host reads a complete
// packet (big-endian sequence header + payload) from the other.
module slave_packet_server
  import slave_packet_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int HDR_WORDS  = DEF_HDR_WORDS,
  parameter bit DEBUG_MODE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        wr_valid,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  input  logic                        ram_rd_rq,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           data_o,
  output logic                        data_valid_o,
  output logic                        rd_err_o,
  output logic                        pkt_ready_o,
  input  logic                        pkt_ack,
  output logic [DATA_W*HDR_WORDS-1:0] seq_o
);

  localparam int SEQ_W  = DATA_W * HDR_WORDS;
  localparam int IDX_W  = idx_width(DEPTH);
  localparam int HIDX_W = idx_width(HDR_WORDS);

  w_state_t          w_state;
  r_state_t          r_state;
  logic [IDX_W-1:0]  wr_ptr;
  logic              wr_bank;
  logic [SEQ_W-1:0]  seq;
  logic              swap;
  logic              wr_en;

  logic              is_hdr;
  logic              is_pay;
  logic [IDX_W-1:0]  pay_idx;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_q;

  logic              s1_valid;
  logic              s1_err;
  logic              s1_hdr;
  logic [HIDX_W-1:0] s1_hidx;
  logic [SEQ_W-1:0]  s1_seq;

  assign swap  = (w_state == W_FULL) && ((r_state == R_EMPTY) || pkt_ack);
  assign wr_en = wr_valid && (w_state == W_FILL);
  assign seq_o = seq;

  // Write and read FSMs share one block because a swap moves both together.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      w_state     <= W_FILL;
      r_state     <= R_EMPTY;
      wr_ptr      <= '0;
      wr_bank     <= 1'b0;
      seq         <= '0;
      wr_ready    <= 1'b1;
      pkt_ready_o <= 1'b0;
    end else if (swap) begin
      wr_bank     <= ~wr_bank;
      seq         <= seq + 1'b1;
      w_state     <= W_FILL;
      wr_ready    <= 1'b1;
      r_state     <= R_HOLD;
      pkt_ready_o <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == IDX_W'(DEPTH - 1)) begin
          w_state  <= W_FULL;
          wr_ready <= 1'b0;
        end
      end
      if ((r_state == R_HOLD) && pkt_ack) begin
        r_state     <= R_EMPTY;
        pkt_ready_o <= 1'b0;
      end
    end
  end

  assign is_hdr    = rd_addr < ADDR_W'(HDR_WORDS);
  assign is_pay    = !is_hdr && (rd_addr < ADDR_W'(HDR_WORDS + DEPTH));
  assign pay_idx   = IDX_W'(rd_addr - ADDR_W'(HDR_WORDS));
  assign ram_rd_en = ram_rd_rq && is_pay;

  // The read bank is always the one the writer is not using.
  pingpong_ram #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .DEBUG_MODE (DEBUG_MODE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_ptr}),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr ({~wr_bank, pay_idx}),
    .rd_data (ram_q)
  );

  // Seq is snapshotted so reads in flight across a swap report the old packet.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_hdr   <= 1'b0;
      s1_hidx  <= '0;
      s1_seq   <= '0;
    end else begin
      s1_valid <= ram_rd_rq;
      s1_err   <= (r_state != R_HOLD) || (!is_hdr && !is_pay);
      s1_hdr   <= is_hdr;
      s1_hidx  <= HIDX_W'(rd_addr);
      s1_seq   <= seq;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      rd_err_o     <= 1'b0;
    end else begin
      data_valid_o <= s1_valid;
      rd_err_o     <= s1_valid && s1_err;
      if (s1_valid) begin
        if (s1_err)
          data_o <= '0;
        else if (s1_hdr)
          data_o <= DATA_W'(hdr_word(MAX_SEQ_W'(s1_seq), int'(s1_hidx), DATA_W, HDR_WORDS));
        else
          data_o <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_slave_packet_server.sv
// Self-checking bench: packet-level model compared every cycle, plus literal
// checks of the directed scenarios; a small second instance exercises seq wrap.
module tb_slave_packet_server;

  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int DEP = 4;
  localparam int HW  = 2;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_rq = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] data_o;
  logic          data_valid_o;
  logic          rd_err_o;
  logic          pkt_ready_o;
  logic          pkt_ack = 1'b0;
  logic [15:0]   seq_o;

  logic          w2_valid = 1'b0;
  logic [3:0]    w2_data = '0;
  logic          w2_ready;
  logic          rq2 = 1'b0;
  logic [15:0]   a2 = '0;
  logic [3:0]    d2;
  logic          v2;
  logic          e2;
  logic          p2;
  logic          ack2 = 1'b0;
  logic [7:0]    seq2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slave_packet_server #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .HDR_WORDS(HW)
  ) dut (
    .clk(clk), .rst_l(rst_l), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .ram_rd_rq(rd_rq), .rd_addr(rd_addr), .data_o(data_o),
    .data_valid_o(data_valid_o), .rd_err_o(rd_err_o), .pkt_ready_o(pkt_ready_o),
    .pkt_ack(pkt_ack), .seq_o(seq_o)
  );

  slave_packet_server #(
    .DATA_W(4), .ADDR_W(16), .DEPTH(2), .HDR_WORDS(2), .DEBUG_MODE(1'b0)
  ) dut_wrap (
    .clk(clk), .rst_l(rst_l), .wr_valid(w2_valid), .wr_data(w2_data),
    .wr_ready(w2_ready), .ram_rd_rq(rq2), .rd_addr(a2), .data_o(d2),
    .data_valid_o(v2), .rd_err_o(e2), .pkt_ready_o(p2),
    .pkt_ack(ack2), .seq_o(seq2)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rq,
                               input logic [AW-1:0] a, input logic ack);
    wr_valid = wv;
    wr_data  = wd;
    rd_rq    = rq;
    rd_addr  = a;
    pkt_ack  = ack;
    @(posedge clk);
    #2;
  endtask

  task automatic readLit(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic exp_e);
    applyStimulus(1'b0, '0, 1'b1, a, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("lit_valid", data_valid_o, 1'b1);
    checkOutput("lit_data", data_o, exp_d);
    checkOutput("lit_err", rd_err_o, exp_e);
  endtask

  // Packet-level model: a fill queue, the held packet, and a 2-deep read pipe.
  logic [DW-1:0] fill_q[$];
  logic [DW-1:0] pkt[DEP];
  bit            held = 0;
  logic [15:0]   m_seq = '0;
  bit            p_valid = 0, p_err = 0, m_valid = 0, m_err = 0;
  logic [DW-1:0] p_data = '0, m_data = '0;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fill_q.delete();
      held    = 0;
      m_seq   = '0;
      p_valid = 0; p_err = 0; p_data = '0;
      m_valid = 0; m_err = 0; m_data = '0;
    end else begin
      bit full;
      m_valid = p_valid;
      m_err   = p_valid && p_err;
      if (p_valid) m_data = p_data;
      p_valid = rd_rq;
      p_err   = 0;
      p_data  = '0;
      if (rd_rq) begin
        if (!held || rd_addr >= HW + DEP) p_err = 1;
        else if (rd_addr < HW) p_data = DW'(m_seq >> (DW * (HW - 1 - int'(rd_addr))));
        else p_data = pkt[rd_addr - HW];
      end
      full = (fill_q.size() == DEP);
      if (!full && wr_valid) fill_q.push_back(wr_data);
      if (full && (!held || pkt_ack)) begin
        for (int i = 0; i < DEP; i++) pkt[i] = fill_q[i];
        fill_q.delete();
        held  = 1;
        m_seq = m_seq + 16'd1;
      end else if (pkt_ack) begin
        held = 0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("data_valid", data_valid_o, m_valid);
    checkOutput("rd_err", rd_err_o, m_err);
    checkOutput("data", data_o, m_data);
    checkOutput("wr_ready", wr_ready, fill_q.size() < DEP);
    checkOutput("pkt_ready", pkt_ready_o, held);
    checkOutput("seq", seq_o, m_seq);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_wr_ready", wr_ready, 1'b1);
    checkOutput("reset_pkt_ready", pkt_ready_o, 1'b0);
    checkOutput("reset_seq", seq_o, 16'h0);
    rst_l = 1'b1;

    // First packet fills an empty reader and swaps on the next cycle.
    applyStimulus(1'b1, 8'h11, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, '0, 1'b0);
    checkOutput("full_wr_ready", wr_ready, 1'b0);
    checkOutput("prefill_pkt_ready", pkt_ready_o, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("swap1_pkt_ready", pkt_ready_o, 1'b1);
    checkOutput("swap1_seq", seq_o, 16'h1);
    checkOutput("swap1_wr_ready", wr_ready, 1'b1);
    readLit(16'd0, 8'h00, 1'b0);
    readLit(16'd1, 8'h01, 1'b0);
    readLit(16'd2, 8'h11, 1'b0);
    readLit(16'd3, 8'h22, 1'b0);
    readLit(16'd4, 8'h33, 1'b0);
    readLit(16'd5, 8'h44, 1'b0);

    // Second fill while packet 1 is held: no swap until ack.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("held_wr_ready", wr_ready, 1'b0);
    checkOutput("held_seq", seq_o, 16'h1);
    readLit(16'd2, 8'h11, 1'b0);

    // Ack with a read issued in the swap cycle, then one right after.
    applyStimulus(1'b0, '0, 1'b1, 16'd3, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 16'd3, 1'b0);
    checkOutput("swap_old_data", data_o, 8'h22);
    checkOutput("swap2_seq", seq_o, 16'h2);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("swap_new_data", data_o, 8'hA1);
    readLit(16'd2, 8'hA0, 1'b0);
    readLit(16'd1, 8'h02, 1'b0);

    // Out-of-range reads.
    readLit(16'd6, 8'h00, 1'b1);
    readLit(16'hFFFF, 8'h00, 1'b1);

    // Reset mid-fill with a read in flight.
    applyStimulus(1'b1, 8'hB0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 16'd2, 1'b0);
    rst_l = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("rst_valid", data_valid_o, 1'b0);
    checkOutput("rst_wr_ready", wr_ready, 1'b1);
    checkOutput("rst_pkt_ready", pkt_ready_o, 1'b0);
    rst_l = 1'b1;
    readLit(16'd2, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("refill_seq", seq_o, 16'h1);
    readLit(16'd5, 8'hC3, 1'b0);

    // Sequence wrap on the 4-bit x 2-word instance (8-bit seq).
    for (int p = 1; p <= 256; p++) begin
      w2_valid = 1'b1; w2_data = 4'(p);
      @(posedge clk); #2;
      w2_data = 4'(p + 5);
      @(posedge clk); #2;
      w2_valid = 1'b0; ack2 = 1'b1;
      @(posedge clk); #2;
      ack2 = 1'b0;
      if (p >= 255) begin
        checkOutput("wrap_seq", seq2, (p == 255) ? 8'hFF : 8'h00);
        rq2 = 1'b1; a2 = 16'd0;
        @(posedge clk); #2;
        a2 = 16'd1;
        @(posedge clk); #2;
        checkOutput("wrap_hdr0", d2, (p == 255) ? 4'hF : 4'h0);
        checkOutput("wrap_hdr0_err", e2, 1'b0);
        a2 = 16'd3;
        @(posedge clk); #2;
        checkOutput("wrap_hdr1", d2, (p == 255) ? 4'hF : 4'h0);
        rq2 = 1'b0;
        @(posedge clk); #2;
        checkOutput("wrap_payload", d2, (p == 255) ? 4'h4 : 4'h5);
        checkOutput("wrap_valid", v2, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
